// File: rtl/snake_turn_queue_if.sv
// Purpose: turn-request / heading bus between the input stage and snake_turn_queue.
// Latency: wires only; all timing is owned by the queue.
// Backpressure: none on the bus; the queue signals rejected requests through drop.
interface snake_turn_queue_if;
    logic       turn_valid;
    logic [1:0] turn_dir;
    logic       step_en;
    logic [3:0] direction;
    logic       dir_changed;
    logic       drop;
    logic [3:0] queue_count;
    logic       queue_full;

    // Request source: drives turns and steps, observes heading and queue status.
    modport master (
        output turn_valid,
        output turn_dir,
        output step_en,
        input  direction,
        input  dir_changed,
        input  drop,
        input  queue_count,
        input  queue_full
    );

    // Queue side.
    modport slave (
        input  turn_valid,
        input  turn_dir,
        input  step_en,
        output direction,
        output dir_changed,
        output drop,
        output queue_count,
        output queue_full
    );
endinterface

// File: rtl/snake_turn_queue.sv
// Purpose: queue of pending snake turns; pops one heading per consumed move (macro SNAKE_RELATIVE_TURN_EN selects relative turns).
// Latency: one cycle from request/step to drop, queue_count, direction and dir_changed.
// Backpressure: none; requests that repeat/reverse the reference heading or hit a full queue without a pop are dropped.
module snake_turn_queue #(
    parameter int DEPTH = 4
) (
    input  logic clock_1hz,
    input  logic reset,
    snake_turn_queue_if.slave tq
);

    localparam int         PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);
    localparam logic [1:0] DIR_RIGHT = 2'b01;

    // Heading storage and pointers; pointers wrap naturally because DEPTH is a power of two.
    logic [1:0]    fifo_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [1:0]    cur_dir;
    logic [3:0]    count_q;
    logic          full_q;
    logic [3:0]    direction_q;
    logic          dir_changed_q;
    logic          drop_q;

    // Next-state signals.
    logic          queue_empty;
    logic [PW-1:0] tail_ptr;
    logic [1:0]    ref_dir;
    logic [1:0]    req_dir;
    logic          rejected;
    logic          pop;
    logic          full_block;
    logic          push;
    logic          drop_nxt;
    logic [1:0]    head_dir;
    logic [1:0]    next_dir;
    logic          changed_nxt;
    logic [3:0]    count_nxt;

    function automatic logic [3:0] dir_onehot(input logic [1:0] d);
        logic [3:0] oh;
        oh    = 4'b0000;
        oh[d] = 1'b1;
        return oh;
    endfunction

    // Classify the incoming request against the reference heading and decide push/pop.
    always_comb begin
        queue_empty = (count_q == 4'd0);
        tail_ptr    = wr_ptr - PW'(1);
        head_dir    = fifo_mem[rd_ptr];
        // The newest queued turn is what the next request must be compared to.
        ref_dir     = queue_empty ? cur_dir : fifo_mem[tail_ptr];
`ifdef SNAKE_RELATIVE_TURN_EN
        // Bit 0 picks left (-1) or right (+1) relative to the reference; a relative
        // turn can never repeat or reverse the reference, so nothing is rejected.
        req_dir     = tq.turn_dir[0] ? (ref_dir + 2'd1) : (ref_dir - 2'd1);
        rejected    = 1'b0;
`else
        req_dir     = tq.turn_dir;
        rejected    = (req_dir == ref_dir) || (req_dir == (ref_dir ^ 2'b10));
`endif
        pop         = tq.step_en && !queue_empty;
        // A full queue still accepts when the same edge frees a slot.
        full_block  = full_q && !pop;
        push        = tq.turn_valid && !rejected && !full_block;
        drop_nxt    = tq.turn_valid && (rejected || full_block);
        next_dir    = pop ? head_dir : cur_dir;
        changed_nxt = pop && (head_dir != cur_dir);
        count_nxt   = count_q + {3'b000, push} - {3'b000, pop};
    end

    // Queue storage write; contents need no reset since count gates every read.
    always_ff @(posedge clock_1hz) begin
        if (reset && push) begin
            fifo_mem[wr_ptr] <= req_dir;
        end
    end

    // Pointers, occupancy, heading and status pulses; reset wins over any request or step.
    always_ff @(posedge clock_1hz) begin
        if (!reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count_q       <= 4'd0;
            full_q        <= 1'b0;
            cur_dir       <= DIR_RIGHT;
            direction_q   <= 4'b0010;
            dir_changed_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q       <= count_nxt;
            full_q        <= (count_nxt == DEPTH_CNT);
            cur_dir       <= next_dir;
            direction_q   <= dir_onehot(next_dir);
            dir_changed_q <= changed_nxt;
            drop_q        <= drop_nxt;
        end
    end

    assign tq.direction   = direction_q;
    assign tq.dir_changed = dir_changed_q;
    assign tq.drop        = drop_q;
    assign tq.queue_count = count_q;
    assign tq.queue_full  = full_q;

endmodule
